// File: rtl/lms_log2_scheduler.sv
// rtl/lms_log2_scheduler.sv - one shared log2 LUT time-multiplexed across the L, M and S channels

// 8-bit integer index to 3.13 log2 lookup; indices above 255 and input 0 both give 0.
module rgb2lab_log2 (
    input  logic        i_rst,
    input  logic [15:0] i_val,
    output logic [15:0] o_log
);

    // Table entry: round(8192 * log2(x)) for 1..255, 0 for x == 0.
    // Built at elaboration from the integer part (msb position) plus 14 fraction bits
    // obtained by repeated squaring of the normalised mantissa (62 fraction bits, so the
    // truncation error stays far below the rounding bit). The 14th bit is then used to round.
    function automatic logic [15:0] log2_entry(input int unsigned x);
        logic [63:0]  m;
        logic [127:0] p;
        logic [16:0]  acc;
        int           e;
        if (x == 0) begin
            return 16'd0;
        end
        e = 0;
        for (int b = 0; b < 8; b++) begin
            if (x[b]) begin
                e = b;
            end
        end
        m   = 64'(x) << (62 - e);
        acc = 17'(e) << 14;
        for (int i = 13; i >= 0; i--) begin
            p = 128'(m) * 128'(m);
            m = p[125:62];
            if (m[63]) begin
                acc[i] = 1'b1;
                m      = m >> 1;
            end
        end
        acc = acc + 17'd1;
        return acc[16:1];
    endfunction

    logic [15:0] lut [256];

    for (genvar g = 0; g < 256; g++) begin : g_lut
        localparam logic [15:0] ENTRY = log2_entry(g);
        assign lut[g] = ENTRY;
    end

    // Values outside the table range have no entry and read as zero; reset also forces zero.
    assign o_log = (i_rst || (i_val[15:8] != 8'd0)) ? 16'd0 : lut[i_val[7:0]];

endmodule

module lms_log2_scheduler #(
    parameter int DATA_W   = 16,
    parameter int CLAMP_EN = 1,
    parameter int CNT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_L,
    input  logic [DATA_W-1:0] i_M,
    input  logic [DATA_W-1:0] i_S,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_log_L,
    output logic [DATA_W-1:0] o_log_M,
    output logic [DATA_W-1:0] o_log_S,
    output logic [2:0]        o_range_err,
    output logic [CNT_W-1:0]  o_pix_cnt
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOG_L = 3'd1;
    localparam logic [2:0] ST_LOG_M = 3'd2;
    localparam logic [2:0] ST_LOG_S = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]        state;
    logic [DATA_W-1:0] cap_L;
    logic [DATA_W-1:0] cap_M;
    logic [DATA_W-1:0] cap_S;
    logic [2:0]        cap_err;
    logic [DATA_W-1:0] sel_raw;
    logic [DATA_W-1:0] log_in;
    logic [DATA_W-1:0] log_out;

    // A raw channel is out of range when it is zero or does not fit the 8-bit table index.
    function automatic logic out_of_range(input logic [DATA_W-1:0] v);
        return (v == '0) || (v[DATA_W-1:8] != '0);
    endfunction

    // Saturate to the last table entry when clamping is enabled.
    function automatic logic [DATA_W-1:0] clamp(input logic [DATA_W-1:0] v);
        if ((CLAMP_EN != 0) && (v[DATA_W-1:8] != '0)) begin
            return DATA_W'(8'd255);
        end
        return v;
    endfunction

    assign o_ready = (state == ST_IDLE) && !i_rst;
    assign o_valid = (state == ST_DONE);

    // Route the captured channel belonging to the current lookup slot into the shared unit.
    always_comb begin
        sel_raw = cap_L;
        case (state)
            ST_LOG_M: sel_raw = cap_M;
            ST_LOG_S: sel_raw = cap_S;
            default:  sel_raw = cap_L;
        endcase
    end

    assign log_in = clamp(sel_raw);

    rgb2lab_log2 u_log2 (
        .i_rst (i_rst),
        .i_val (log_in),
        .o_log (log_out)
    );

    // Sequencer: accept in IDLE, one lookup per cycle for L, M, S, then hold until taken.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (i_valid) state <= ST_LOG_L;
                ST_LOG_L: state <= ST_LOG_M;
                ST_LOG_M: state <= ST_LOG_S;
                ST_LOG_S: state <= ST_DONE;
                ST_DONE:  if (i_ready) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Capture the incoming triple and its range flags on the accept handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cap_L   <= '0;
            cap_M   <= '0;
            cap_S   <= '0;
            cap_err <= '0;
        end else if ((state == ST_IDLE) && i_valid) begin
            cap_L   <= i_L;
            cap_M   <= i_M;
            cap_S   <= i_S;
            cap_err <= {out_of_range(i_S), out_of_range(i_M), out_of_range(i_L)};
        end
    end

    // Register each lookup result into its channel output; flags go out with the last one
    // so the whole output set changes together and then holds until the next pixel.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_log_L     <= '0;
            o_log_M     <= '0;
            o_log_S     <= '0;
            o_range_err <= '0;
        end else begin
            case (state)
                ST_LOG_L: o_log_L <= log_out;
                ST_LOG_M: o_log_M <= log_out;
                ST_LOG_S: begin
                    o_log_S     <= log_out;
                    o_range_err <= cap_err;
                end
                default: ;
            endcase
        end
    end

    // Count completed output handshakes; wraps silently.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pix_cnt <= '0;
        end else if ((state == ST_DONE) && i_ready) begin
            o_pix_cnt <= o_pix_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_lms_log2_scheduler.sv
// tb/tb_lms_log2_scheduler.sv - randomized self-checking bench for lms_log2_scheduler
module tb_lms_log2_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [15:0] i_L, i_M, i_S;

    wire [2:0]        ordy;
    wire [2:0]        ovalid;
    wire [2:0][15:0]  log_l, log_m, log_s, pcnt;
    wire [2:0][2:0]   rerr;
    wire [3:0]        cnt_c4;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int exp_cnt [3];

    always #5 clk = ~clk;

    lms_log2_scheduler #(.DATA_W(16), .CLAMP_EN(1), .CNT_W(16)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(ordy[0]),
        .i_L(i_L), .i_M(i_M), .i_S(i_S), .o_valid(ovalid[0]), .i_ready(i_ready),
        .o_log_L(log_l[0]), .o_log_M(log_m[0]), .o_log_S(log_s[0]),
        .o_range_err(rerr[0]), .o_pix_cnt(pcnt[0]));

    lms_log2_scheduler #(.DATA_W(16), .CLAMP_EN(0), .CNT_W(16)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(ordy[1]),
        .i_L(i_L), .i_M(i_M), .i_S(i_S), .o_valid(ovalid[1]), .i_ready(i_ready),
        .o_log_L(log_l[1]), .o_log_M(log_m[1]), .o_log_S(log_s[1]),
        .o_range_err(rerr[1]), .o_pix_cnt(pcnt[1]));

    lms_log2_scheduler #(.DATA_W(16), .CLAMP_EN(1), .CNT_W(4)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(ordy[2]),
        .i_L(i_L), .i_M(i_M), .i_S(i_S), .o_valid(ovalid[2]), .i_ready(i_ready),
        .o_log_L(log_l[2]), .o_log_M(log_m[2]), .o_log_S(log_s[2]),
        .o_range_err(rerr[2]), .o_pix_cnt(cnt_c4));

    assign pcnt[2] = {12'd0, cnt_c4};

    // Reference: rounded 8192*log2 of the (optionally clamped) channel, 0 when off-table.
    function automatic logic [15:0] ref_log(input int v, input bit clamp_on);
        int  x;
        real r;
        x = v;
        if (x > 255) begin
            if (!clamp_on) return 16'h0000;
            x = 255;
        end
        if (x == 0) return 16'h0000;
        r = $ln(real'(x)) / $ln(2.0) * 8192.0;
        return 16'($rtoi(r + 0.5));
    endfunction

    function automatic logic [47:0] ref_logs(input int l, input int m, input int s, input int k);
        bit c;
        c = (k != 1);
        return {ref_log(l, c), ref_log(m, c), ref_log(s, c)};
    endfunction

    function automatic logic [2:0] ref_err(input int l, input int m, input int s);
        return {(s == 0 || s > 255), (m == 0 || m > 255), (l == 0 || l > 255)};
    endfunction

    function automatic logic [15:0] ref_cnt(input int k);
        return (k == 2) ? 16'(exp_cnt[k] % 16) : 16'(exp_cnt[k] % 65536);
    endfunction

    function automatic int rand_chan();
        case ($urandom_range(0, 9))
            0:       return 0;
            1:       return int'($urandom_range(256, 65535));
            2:       return 1;
            default: return int'($urandom_range(2, 255));
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Offer one triple, wait for acceptance, then count cycles until o_valid (bounded).
    task automatic run_pixel(input int l, input int m, input int s, output int lat);
        int guard;
        guard = 0;
        while (!ordy[0] && guard < 20) begin
            tick();
            guard++;
        end
        i_valid = 1'b1;
        i_L = 16'(l);
        i_M = 16'(m);
        i_S = 16'(s);
        tick();
        i_valid = 1'b0;
        lat = 1;
        while (!ovalid[0] && lat < 24) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) exp_cnt[k]++;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_L = '0; i_M = '0; i_S = '0;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (ordy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_ready_held dut%0d: got %b want 0", k, ordy[k]); end
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_cnt[k] = 0;
            n_cmp++;
            if ({ordy[k], ovalid[k], log_l[k], log_m[k], log_s[k], rerr[k], pcnt[k]} !== {1'b1, 1'b0, 48'h0, 3'b000, 16'h0}) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got rdy=%b vld=%b logs=%h/%h/%h err=%b cnt=%0d want rdy=1 vld=0 all zero",
                         k, ordy[k], ovalid[k], log_l[k], log_m[k], log_s[k], rerr[k], pcnt[k]);
            end
        end
    endtask

    task automatic test_basic();
        int lat;
        run_pixel(128, 2, 3, lat);
        n_cmp++;
        if (lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", lat); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({ovalid[k], log_l[k], log_m[k], log_s[k], rerr[k]} !== {1'b1, 16'hE000, 16'h2000, 16'h32B8, 3'b000}) begin
                n_fail++;
                $display("FAIL basic_out dut%0d: got vld=%b %h/%h/%h err=%b want 1 E000/2000/32B8 000",
                         k, ovalid[k], log_l[k], log_m[k], log_s[k], rerr[k]);
            end
        end
        handshake();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({ovalid[k], pcnt[k]} !== {1'b0, 16'd1}) begin
                n_fail++; $display("FAIL basic_count dut%0d: got vld=%b cnt=%0d want 0 1", k, ovalid[k], pcnt[k]);
            end
        end
    endtask

    task automatic test_zero_one();
        int lat;
        run_pixel(192, 1, 0, lat);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({log_l[k], log_m[k], log_s[k], rerr[k]} !== {16'hF2B8, 16'h0000, 16'h0000, 3'b100}) begin
                n_fail++;
                $display("FAIL zero_one dut%0d: got %h/%h/%h err=%b want F2B8/0000/0000 100",
                         k, log_l[k], log_m[k], log_s[k], rerr[k]);
            end
        end
        handshake();
    endtask

    task automatic test_clamp();
        int lat;
        logic [15:0] want_l;
        run_pixel(300, 7, 255, lat);
        for (int k = 0; k < 3; k++) begin
            want_l = (k == 1) ? 16'h0000 : 16'hFFD2;
            n_cmp++;
            if ({log_l[k], rerr[k][0]} !== {want_l, 1'b1}) begin
                n_fail++;
                $display("FAIL clamp dut%0d: got L=%h err0=%b want %h 1", k, log_l[k], rerr[k][0], want_l);
            end
            n_cmp++;
            if ({log_l[k], log_m[k], log_s[k]} !== ref_logs(300, 7, 255, k)) begin
                n_fail++;
                $display("FAIL clamp_model dut%0d: got %h/%h/%h want %h", k, log_l[k], log_m[k], log_s[k], ref_logs(300, 7, 255, k));
            end
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int l, m, s, lat, bad;
        l = rand_chan(); m = rand_chan(); s = rand_chan();
        run_pixel(l, m, s, lat);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            i_L = 16'($urandom);
            i_valid = 1'b1;
            tick();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if ({ovalid[k], ordy[k], log_l[k], log_m[k], log_s[k], rerr[k]} !== {1'b1, 1'b0, ref_logs(l, m, s, k), ref_err(l, m, s)}) begin
                    n_fail++;
                    $display("FAIL stall c%0d dut%0d: got vld=%b rdy=%b %h/%h/%h err=%b want 1 0 %h %b",
                             c, k, ovalid[k], ordy[k], log_l[k], log_m[k], log_s[k], rerr[k], ref_logs(l, m, s, k), ref_err(l, m, s));
                end
            end
        end
        i_valid = 1'b0;
        handshake();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (pcnt[k] !== ref_cnt(k)) begin n_fail++; $display("FAIL stall_count dut%0d: got %0d want %0d", k, pcnt[k], ref_cnt(k)); end
        end
    endtask

    task automatic test_reset_mid();
        int l, m, s, lat;
        i_valid = 1'b1; i_L = 16'd77; i_M = 16'd88; i_S = 16'd99;
        tick();
        i_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_cnt[k] = 0;
            n_cmp++;
            if ({ordy[k], ovalid[k], log_l[k], log_m[k], log_s[k], rerr[k], pcnt[k]} !== {1'b1, 1'b0, 48'h0, 3'b000, 16'h0}) begin
                n_fail++;
                $display("FAIL midreset dut%0d: got rdy=%b vld=%b %h/%h/%h err=%b cnt=%0d want 1 0 zeros",
                         k, ordy[k], ovalid[k], log_l[k], log_m[k], log_s[k], rerr[k], pcnt[k]);
            end
        end
        l = rand_chan(); m = rand_chan(); s = rand_chan();
        run_pixel(l, m, s, lat);
        n_cmp++;
        if (lat !== 4) begin n_fail++; $display("FAIL midreset_latency: got %0d want 4", lat); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({log_l[k], log_m[k], log_s[k], rerr[k]} !== {ref_logs(l, m, s, k), ref_err(l, m, s)}) begin
                n_fail++;
                $display("FAIL midreset_pixel dut%0d: got %h/%h/%h err=%b want %h %b",
                         k, log_l[k], log_m[k], log_s[k], rerr[k], ref_logs(l, m, s, k), ref_err(l, m, s));
            end
        end
        handshake();
    endtask

    task automatic test_random();
        int l, m, s, lat, stall;
        for (int p = 0; p < 12; p++) begin
            l = rand_chan(); m = rand_chan(); s = rand_chan();
            run_pixel(l, m, s, lat);
            n_cmp++;
            if (lat !== 4) begin n_fail++; $display("FAIL rand_latency p%0d: got %0d want 4", p, lat); end
            stall = int'($urandom_range(0, 3));
            for (int c = 0; c < stall; c++) tick();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if ({ovalid[k], log_l[k], log_m[k], log_s[k], rerr[k], pcnt[k]} !== {1'b1, ref_logs(l, m, s, k), ref_err(l, m, s), ref_cnt(k)}) begin
                    n_fail++;
                    $display("FAIL rand p%0d dut%0d in=%0d,%0d,%0d: got vld=%b %h/%h/%h err=%b cnt=%0d want 1 %h %b %0d",
                             p, k, l, m, s, ovalid[k], log_l[k], log_m[k], log_s[k], rerr[k], pcnt[k],
                             ref_logs(l, m, s, k), ref_err(l, m, s), ref_cnt(k));
                end
            end
            handshake();
        end
    endtask

    task automatic test_back_to_back();
        int ql[$], qm[$], qs[$];
        int l, m, s, seen, prev, budget;
        bit acc;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) exp_cnt[k] = 0;
        l = rand_chan(); m = rand_chan(); s = rand_chan();
        i_L = 16'(l); i_M = 16'(m); i_S = 16'(s);
        i_valid = 1'b1;
        i_ready = 1'b1;
        #1;
        seen = 0; prev = -1; budget = 0;
        while (seen < 17 && budget < 200) begin
            acc = ordy[0];
            tick();
            budget++;
            if (acc) begin
                ql.push_back(l); qm.push_back(m); qs.push_back(s);
                l = rand_chan(); m = rand_chan(); s = rand_chan();
                i_L = 16'(l); i_M = 16'(m); i_S = 16'(s);
            end
            if (ovalid[0]) begin
                if (ql.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL b2b_unexpected_output: got output with no accepted pixel want none");
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        n_cmp++;
                        if ({log_l[k], log_m[k], log_s[k], rerr[k], pcnt[k]} !== {ref_logs(ql[0], qm[0], qs[0], k), ref_err(ql[0], qm[0], qs[0]), ref_cnt(k)}) begin
                            n_fail++;
                            $display("FAIL b2b pix%0d dut%0d: got %h/%h/%h err=%b cnt=%0d want %h %b %0d",
                                     seen, k, log_l[k], log_m[k], log_s[k], rerr[k], pcnt[k],
                                     ref_logs(ql[0], qm[0], qs[0], k), ref_err(ql[0], qm[0], qs[0]), ref_cnt(k));
                        end
                    end
                    void'(ql.pop_front()); void'(qm.pop_front()); void'(qs.pop_front());
                end
                if (prev >= 0) begin
                    n_cmp++;
                    if (cyc - prev !== 5) begin n_fail++; $display("FAIL b2b_spacing pix%0d: got %0d want 5", seen, cyc - prev); end
                end
                prev = cyc;
                seen++;
                for (int k = 0; k < 3; k++) exp_cnt[k]++;
                if (seen == 17) i_valid = 1'b0;
            end
        end
        n_cmp++;
        if (seen !== 17) begin n_fail++; $display("FAIL b2b_timeout: got %0d outputs want 17", seen); end
        tick();
        i_ready = 1'b0;
        n_cmp++;
        if ({pcnt[2], pcnt[0]} !== {16'd1, 16'd17}) begin
            n_fail++; $display("FAIL b2b_final_count: got c4=%0d c16=%0d want 1 17", pcnt[2], pcnt[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_one();
        test_clamp();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
